// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate response checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    typedef logic [1:0] vec_t;

    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;

    function automatic logic [3:0] vec_onehot(input vec_t v);
        return 4'b0001 << v;
    endfunction

endpackage

// File: rtl/gate_chk_sat_counter.sv
// Saturating up-counter with synchronous clear, used for mismatch counting.
module gate_chk_sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {ERR_W{1'b1}})) begin
            count_d = count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gate_response_checker.sv
// Checks a 2-input gate's responses against TRUTH_TABLE over a coverage-driven run.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE    = NAND_TT,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             in1,
    input  logic             in2,
    input  logic             out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    localparam int              CYC_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CYC_W-1:0] TO_LIM = CYC_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cov_q, cov_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             to_q, to_d;
    logic             ffv_q, ffv_d;
    vec_t             ffvec_q, ffvec_d;
    logic             err_clr, err_inc;
    vec_t             vec;
    logic             hit_mismatch;
    logic             err_nz;

    assign vec          = {in1, in2};
    assign hit_mismatch = sample_valid && (out != TRUTH_TABLE[vec]);
    // Error total after this cycle is nonzero if one is already counted or one lands now.
    assign err_nz       = (err_count != '0) || hit_mismatch;

    gate_chk_sat_counter #(
        .ERR_W(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (err_clr),
        .inc  (err_inc),
        .count(err_count)
    );

    always_comb begin
        state_d = state_q;
        cov_d   = cov_q;
        cyc_d   = cyc_q;
        to_d    = to_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        err_clr = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (sample_valid) begin
                    cov_d = cov_q | vec_onehot(vec);
                end
                if (hit_mismatch) begin
                    err_inc = 1'b1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec;
                    end
                end
                // Completion outranks both early-stop and timeout.
                if (cov_d == 4'hF) begin
                    state_d = err_nz ? FAIL : PASS;
                end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                else if (hit_mismatch) begin
                    state_d = FAIL;
                end
`endif
                else if (cyc_d == TO_LIM) begin
                    state_d = FAIL;
                    to_d    = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    cov_d   = '0;
                    cyc_d   = '0;
                    to_d    = 1'b0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    err_clr = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cov_q   <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            cov_q   <= cov_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign busy             = (state_q == RUN);
    assign done             = (state_q == PASS) || (state_q == FAIL);
    assign pass             = (state_q == PASS);
    assign timeout          = to_q;
    assign coverage         = cov_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 SHALL have parameter TRUTH_TABLE, default 4'b0111, expected out indexed by {in1,in2} (NAND).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum RUN cycles before timeout.
REQ-003 SHALL have parameter ERR_W, default 8, width of err_count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a check run.
REQ-007 sample_valid  input  1  in1/in2/out form a valid observation this cycle.
REQ-008 in1  input  1  stimulus A applied to the gate under test.
REQ-009 in2  input  1  stimulus B applied to the gate under test.
REQ-010 out  input  1  response O of the gate under test.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  run finished; held until next start or rst.
REQ-013 pass  output  1  valid only while done=1.
REQ-014 timeout  output  1  run ended by timeout.
REQ-015 err_count  output  ERR_W  mismatches in current run, saturating.
REQ-016 coverage  output  4  bit i set once vector {in1,in2}=i was sampled.
REQ-017 first_fail_valid  output  1  a mismatch has been captured.
REQ-018 first_fail_vec  output  2  {in1,in2} of the first mismatch.

Function
REQ-019 FSM states SHALL be IDLE, RUN, PASS, FAIL.
REQ-020 IDLE/PASS/FAIL -> RUN on start; start SHALL clear err_count, coverage, first_fail_*, timeout, done, pass, and the cycle counter.
REQ-021 start during RUN SHALL be ignored.
REQ-022 In RUN, each sample_valid SHALL set coverage[{in1,in2}] and compare out against TRUTH_TABLE[{in1,in2}].
REQ-023 Outputs SHALL reflect a sample one cycle after sample_valid (registered, latency 1).
REQ-024 On mismatch, err_count SHALL increment and saturate at 2^ERR_W-1.
REQ-025 first_fail_vec SHALL capture only the first mismatch of a run; later mismatches SHALL not overwrite it.
REQ-026 Repeated samples of an already-covered vector SHALL still be checked and counted.
REQ-027 RUN -> PASS when coverage becomes 4'hF with err_count=0, in the cycle after the completing sample.
REQ-028 RUN -> FAIL when coverage becomes 4'hF with err_count>0.
REQ-029 Cycle counter SHALL count every RUN cycle; on reaching TIMEOUT_CYCLES with coverage!=4'hF, RUN -> FAIL with timeout=1.
REQ-030 If coverage completes on the timeout cycle, completion SHALL take priority (no timeout).
REQ-031 sample_valid outside RUN SHALL be ignored.
REQ-032 busy=1 only in RUN; done=1 in PASS or FAIL; pass=1 only in PASS.

Reset
REQ-033 rst SHALL force IDLE and zero every output and internal counter, and SHALL override start and sample_valid in the same cycle.
REQ-034 rst mid-RUN SHALL abandon the run with no result reported.

Configuration
REQ-035 With GATE_CHK_STOP_ON_FAIL_EN defined, the first mismatch SHALL move RUN -> FAIL in the cycle after the failing sample, regardless of coverage.
REQ-036 Without GATE_CHK_STOP_ON_FAIL_EN, the run SHALL continue until full coverage or timeout (REQ-027..029).

Structure
REQ-037 Package gate_chk_pkg SHALL hold the state enum, the 2-bit vector type, and constants NAND_TT=4'b0111, AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110.
REQ-038 Saturating error counter SHALL be sub-module gate_chk_sat_counter (parameter ERR_W; ports clr, inc, count).

Verification
REQ-039 Correct NAND, start, samples 00,10,11,01 -> coverage=4'hF, done=1, pass=1, err_count=0.
REQ-040 Faulty gate (out=1 at 11), samples 00,10,11,01 -> FAIL, err_count=1, first_fail_vec=2'b11; with GATE_CHK_STOP_ON_FAIL_EN, FAIL occurs the cycle after the 11 sample.
REQ-041 TIMEOUT_CYCLES=16, only vectors 00 and 01 sampled -> after 16 RUN cycles FAIL, timeout=1, coverage=4'b0011.
REQ-042 ERR_W=2, stuck-at-0 gate, 5 repeated samples of 00 -> err_count saturates at 3; first_fail_vec=2'b00.
REQ-043 rst asserted after 2 samples -> all outputs 0 next cycle; new start gives a clean run that passes.
REQ-044 start during RUN and sample_valid in IDLE -> no state change, no coverage or err_count change.
